// File: rtl/div_share_ctrl_if.sv
// Bundle of requester-side and divider-side signals for div_share_ctrl.
// master = the sharing controller, slave = requesters plus the divider datapath.
interface div_share_ctrl_if #(
  parameter int N = 4,
  parameter int W = 10
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_q;
  logic           rsp_ov;
  logic           rsp_dvz;
  logic           rsp_to;
  logic           div_clr;
  logic           div_ld_a;
  logic           div_ld_b;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_loading_done;
  logic           div_start;
  logic [W-1:0]   div_q;
  logic           div_ov;
  logic           div_dvz;
  logic           div_done;

  modport master (
    input  req, a_in, b_in, div_q, div_ov, div_dvz, div_done,
    output gnt, rsp_valid, rsp_q, rsp_ov, rsp_dvz, rsp_to,
           div_clr, div_ld_a, div_ld_b, div_a, div_b, div_loading_done, div_start
  );

  modport slave (
    output req, a_in, b_in, div_q, div_ov, div_dvz, div_done,
    input  gnt, rsp_valid, rsp_q, rsp_ov, rsp_dvz, rsp_to,
           div_clr, div_ld_a, div_ld_b, div_a, div_b, div_loading_done, div_start
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin sequencer sharing one fixed-point divider among N requesters:
// grants one operand pair at a time, runs the divider handshake, returns the result.
module div_share_ctrl #(
  parameter int N       = 4,
  parameter int W       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  div_share_ctrl_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0]  ONE_HOT = N'(1);
  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, START, WAIT, RESP} state_t;

  state_t         state_reg;
  logic [IW-1:0]  ptr_reg;
  logic [CW-1:0]  cnt_reg;

  logic [W-1:0]   a_slice [N];
  logic [W-1:0]   b_slice [N];
  logic [IW-1:0]  cand;
  logic [IW-1:0]  win_idx;
  logic           win_found;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign a_slice[gi] = bus.a_in[gi*W +: W];
    assign b_slice[gi] = bus.b_in[gi*W +: W];
  end

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_reg;
    for (int k = 0; k < N; k++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg            <= IDLE;
      ptr_reg              <= LAST;
      cnt_reg              <= '0;
      bus.gnt              <= '0;
      bus.rsp_valid        <= '0;
      bus.rsp_q            <= '0;
      bus.rsp_ov           <= 1'b0;
      bus.rsp_dvz          <= 1'b0;
      bus.rsp_to           <= 1'b0;
      bus.div_clr          <= 1'b1;
      bus.div_ld_a         <= 1'b0;
      bus.div_ld_b         <= 1'b0;
      bus.div_a            <= '0;
      bus.div_b            <= '0;
      bus.div_loading_done <= 1'b0;
      bus.div_start        <= 1'b0;
    end else begin
      bus.gnt       <= '0;
      bus.div_clr   <= 1'b0;
      bus.div_ld_a  <= 1'b0;
      bus.div_ld_b  <= 1'b0;
      bus.div_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            ptr_reg    <= win_idx;
            bus.gnt    <= ONE_HOT << win_idx;
            bus.div_a  <= a_slice[win_idx];
            bus.div_b  <= b_slice[win_idx];
            bus.rsp_ov <= 1'b0;
            bus.rsp_to <= 1'b0;
            if (b_slice[win_idx] == '0) begin
              // Zero divisor never touches the divider.
              bus.rsp_q   <= '0;
              bus.rsp_dvz <= 1'b1;
              state_reg   <= RESP;
            end else begin
              bus.div_clr <= 1'b1;
              state_reg   <= CLR;
            end
          end
        end
        CLR: begin
          bus.div_ld_a <= 1'b1;
          bus.div_ld_b <= 1'b1;
          state_reg    <= LOAD;
        end
        LOAD: begin
          bus.div_start        <= 1'b1;
          bus.div_loading_done <= 1'b1;
          state_reg            <= START;
        end
        START: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.div_done) begin
            bus.rsp_q            <= bus.div_q;
            bus.rsp_ov           <= bus.div_ov;
            bus.rsp_dvz          <= bus.div_dvz;
            bus.rsp_to           <= 1'b0;
            bus.rsp_valid        <= ONE_HOT << ptr_reg;
            bus.div_loading_done <= 1'b0;
            state_reg            <= RESP;
          end else if (cnt_reg == CNT_MAX) begin
            bus.rsp_q            <= '0;
            bus.rsp_ov           <= 1'b0;
            bus.rsp_dvz          <= 1'b0;
            bus.rsp_to           <= 1'b1;
            bus.rsp_valid        <= ONE_HOT << ptr_reg;
            bus.div_loading_done <= 1'b0;
            state_reg            <= RESP;
          end
        end
        RESP: begin
          // The divide-by-zero path arrives with the pulse not yet raised.
          if (bus.rsp_valid == '0) begin
            bus.rsp_valid <= ONE_HOT << ptr_reg;
          end else begin
            bus.rsp_valid <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequencer and round-robin arbiter that shares one 10-bit `fixed_point_division` datapath among `N` requesters. It accepts operand pairs, grants one requester at a time, and drives the divider's clear, load, loading-done and start controls. It waits for the divider's completion flag, then returns the quotient and status to the winner. It short-circuits divide-by-zero and bounds every operation with a timeout.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 10: operand/quotient width.
- `TIMEOUT`, 64: max cycles in WAIT before abort; counter width `$clog2(TIMEOUT+1)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in N: per-requester request level.
- `a_in` in N*W: dividends, requester i at bits [i*W +: W].
- `b_in` in N*W: divisors, same packing.
- `gnt` out N: one-hot, one-cycle grant pulse.
- `rsp_valid` out N: one-hot, one-cycle response pulse to the granted requester.
- `rsp_q` out W: quotient, valid with `rsp_valid`.
- `rsp_ov`, `rsp_dvz`, `rsp_to` out 1 each: overflow, divide-by-zero, timeout flags, valid with `rsp_valid`.
- `div_clr` out 1: active-high clear to the divider.
- `div_ld_a`, `div_ld_b` out 1 each: operand load strobes.
- `div_a`, `div_b` out W each: latched operands.
- `div_loading_done` out 1: operands stable.
- `div_start` out 1: start pulse.
- `div_q` in W, `div_ov` in 1, `div_dvz` in 1: divider results.
- `div_done` in 1: divider completion (counter carry-out), sampled only in WAIT.

## Operation
- States: IDLE, CLR, LOAD, START, WAIT, RESP.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin, searching from `ptr+1` upward with wrap.
  - Latch `a_in`/`b_in` of the winner into `div_a`/`div_b`.
  - Set `ptr` = winner and pulse `gnt[winner]`.
  - If the latched B is 0, go to RESP with `rsp_dvz`=1, `rsp_q`=0, `rsp_ov`=0. Otherwise go to CLR.
- CLR: `div_clr`=1 for one cycle, then LOAD.
- LOAD: `div_ld_a`=`div_ld_b`=1 for one cycle, then START.
- START: `div_start`=1 for one cycle, `div_loading_done`=1, then WAIT.
- WAIT:
  - `div_loading_done` stays 1; the cycle counter increments each cycle.
  - If `div_done`=1: capture `div_q`/`div_ov`/`div_dvz` and go to RESP.
  - Else if the counter equals TIMEOUT-1: go to RESP with `rsp_to`=1, `rsp_q`=0.
- RESP: `rsp_valid[winner]`=1 for one cycle with the result fields, then IDLE.
- Requesters drop `req` in the cycle after `gnt`. A `req` still high on return to IDLE is a new request.
- The `a_in`/`b_in` values of non-granted requesters are ignored until they win.
- `div_a`/`div_b` hold from the grant until the next grant.
- Priority: `div_done` beats timeout when both occur on the same edge.

## Timing
- All outputs are registered.
- Reset (`rst`=0 at an edge), from any state:
  - state=IDLE, `ptr`=N-1 (first search starts at requester 0).
  - All `gnt`/`rsp_*`/`div_*` outputs are 0, except `div_clr`=1 while `rst`=0.
  - The counter is cleared.
  - An in-flight result is discarded with no `rsp_valid`.
- `req` sampled at edge k (IDLE):
  - `gnt` high for cycle k+1.
  - `div_clr` at k+1, ld at k+2, `div_start` at k+3.
  - WAIT from k+4.
- `div_done` sampled at edge m: `rsp_valid` high for cycle m+1, IDLE at m+2.
- Divide-by-zero path: `gnt` and `rsp_valid` in consecutive cycles k+1 and k+2.
- Back-to-back: the earliest next grant is 2 cycles after `rsp_valid`.
- Timeout: `rsp_valid` asserts TIMEOUT+1 cycles after START.

## Test plan
- Single request: req[0], A=10'b0001101110, B=10'd3. The model asserts `div_done` 12 cycles after start with q=Q_ref.
  - Expected: `gnt`=4'b0001 at k+1; ld at k+2; start at k+3.
  - Expected: `rsp_valid`=4'b0001 with `rsp_q`=Q_ref at done+1.
- Round-robin: `req`=4'b1111 held constant.
  - Expected: grants ordered 0, 1, 2, 3, 0, each followed by its matching `rsp_valid` before the next `gnt`.
- Divide-by-zero: req[2] with B=0.
  - Expected: `gnt`=4'b0100, then next cycle `rsp_valid`=4'b0100, `rsp_dvz`=1, `rsp_q`=0.
  - Expected: `div_clr`/ld/start never pulse.
- Timeout: model never asserts `div_done`.
  - Expected: `rsp_to`=1 exactly TIMEOUT+1 cycles after `div_start`; next request is served normally.
- Reset mid-operation: `rst`=0 for one edge during WAIT.
  - Expected: no `rsp_valid`, all outputs 0.
  - Expected: next request from requester 0 is granted first.
- Done/timeout collision: `div_done` asserted on the cycle the counter reaches TIMEOUT-1.
  - Expected: `rsp_to`=0, with the quotient from the divider.
